// File: rtl/im_loader.sv
// Boot loader for the instruction memory: turns a length-prefixed, XOR-checked
// byte stream into 32-bit block RAM writes and releases the CPU once verified.
module im_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 2048,
    parameter int BASE      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [3:0]        im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_din,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    state_t      state;
    state_t      state_next;
    logic [15:0] len;
    logic [15:0] len_rx;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [23:0] shift_word;
    logic        oversize;
    logic        last_word;

    assign len_rx    = {len[15:8], rx_data};
    assign oversize  = (32'(len_rx) > 32'(MAX_WORDS));
    assign last_word = ((16'(words_loaded) + 16'd1) == len);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_LEN_HI;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            cpu_hold <= (state_next != S_DONE);
            done     <= (state_next == S_DONE);
            err      <= (state_next == S_ERR);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN_HI: if (rx_valid) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (rx_valid) begin
                    if (oversize)
                        state_next = S_ERR;
                    else if (len_rx == 16'd0)
                        state_next = S_CSUM;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid && byte_idx == 2'd3 && last_word)
                    state_next = S_CSUM;
            end
            S_CSUM: begin
                if (rx_valid)
                    state_next = (rx_data == csum) ? S_DONE : S_ERR;
            end
            default: state_next = state;
        endcase
    end

    // Write pulse defaults low every cycle; address and data only move on a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_we        <= 4'b0000;
            im_addr      <= '0;
            im_din       <= 32'd0;
            words_loaded <= '0;
            len          <= 16'd0;
            csum         <= 8'd0;
            byte_idx     <= 2'd0;
            shift_word   <= 24'd0;
        end else begin
            im_we <= 4'b0000;
            if (rx_valid) begin
                case (state)
                    S_LEN_HI: begin
                        len[15:8] <= rx_data;
                        csum      <= csum ^ rx_data;
                    end
                    S_LEN_LO: begin
                        len[7:0] <= rx_data;
                        csum     <= csum ^ rx_data;
                    end
                    S_DATA: begin
                        csum       <= csum ^ rx_data;
                        byte_idx   <= byte_idx + 2'd1;
                        shift_word <= {shift_word[15:0], rx_data};
                        if (byte_idx == 2'd3) begin
                            im_we        <= 4'b1111;
                            im_addr      <= BASE_A + words_loaded[ADDR_W-1:0];
                            im_din       <= {shift_word, rx_data};
                            words_loaded <= words_loaded + (ADDR_W+1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: two instances (BASE 0 and BASE 1120) share one byte
// stream; writes and status are checked against a stream-level model.
module tb_im_loader;

    typedef struct packed {
        logic [31:0] edge_n;
        logic [3:0]  we;
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [3:0]  we0, we1;
    logic [10:0] addr0, addr1;
    logic [31:0] din0, din1;
    logic        hold0, hold1, done0, done1, err0, err1;
    logic [11:0] wl0, wl1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] tx[$];
    int         edges[$];
    wr_t        got0[$], got1[$], exp0[$], exp1[$];
    logic       expDone, expErr;
    int         expWords;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    im_loader #(.ADDR_W(11), .MAX_WORDS(2048), .BASE(0)) dut0 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .im_we(we0), .im_addr(addr0), .im_din(din0), .cpu_hold(hold0),
        .done(done0), .err(err0), .words_loaded(wl0));

    im_loader #(.ADDR_W(11), .MAX_WORDS(2048), .BASE(1120)) dut1 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .im_we(we1), .im_addr(addr1), .im_din(din1), .cpu_hold(hold1),
        .done(done1), .err(err1), .words_loaded(wl1));

    // Every non-idle write-enable cycle is logged with the edge that produced it.
    always @(negedge clk) begin
        if (we0 !== 4'h0) got0.push_back({32'(cyc), we0, addr0, din0});
        if (we1 !== 4'h0) got1.push_back({32'(cyc), we1, addr1, din1});
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        edges.push_back(cyc + 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic sendStream(input int gapLo, input int gapHi);
        edges.delete();
        foreach (tx[i]) applyStimulus(tx[i], $urandom_range(gapHi, gapLo));
    endtask

    task automatic doReset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        got0.delete();
        got1.delete();
        tx.delete();
    endtask

    function automatic logic [7:0] xorOf();
        logic [7:0] x = 8'h00;
        foreach (tx[i]) x ^= tx[i];
        return x;
    endfunction

    // Stream-level model: length, words, trailing XOR byte; later bytes ignored.
    function automatic void buildModel();
        int         n;
        int         idx;
        int         j;
        logic [7:0] x;
        logic [31:0] word;
        exp0.delete();
        exp1.delete();
        expDone  = 1'b0;
        expErr   = 1'b0;
        expWords = 0;
        n = {tx[0], tx[1]};
        if (n > 2048) begin
            expErr = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            j = 2 + 4 * k;
            if (j + 3 < tx.size()) begin
                word = {tx[j], tx[j+1], tx[j+2], tx[j+3]};
                exp0.push_back({32'(edges[j+3]), 4'hF, 11'(k), word});
                exp1.push_back({32'(edges[j+3]), 4'hF, 11'(1120 + k), word});
                expWords++;
            end
        end
        idx = 2 + 4 * n;
        if (idx < tx.size()) begin
            x = 8'h00;
            for (int i = 0; i < idx; i++) x ^= tx[i];
            if (tx[idx] == x) expDone = 1'b1;
            else expErr = 1'b1;
        end
    endfunction

    task automatic test_reset();
        doReset();
        checks++;
        if ({we0, addr0, din0, hold0, done0, err0, wl0} !== {4'h0, 11'h0, 32'h0, 1'b1, 1'b0, 1'b0, 12'h0}) begin
            errors++;
            $display("[TB] FAIL reset_dut0: got %h expected %h",
                     {we0, addr0, din0, hold0, done0, err0, wl0}, {4'h0, 11'h0, 32'h0, 1'b1, 1'b0, 1'b0, 12'h0});
        end
        checks++;
        if ({we1, addr1, din1, hold1, done1, err1, wl1} !== {4'h0, 11'h0, 32'h0, 1'b1, 1'b0, 1'b0, 12'h0}) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got %h expected %h",
                     {we1, addr1, din1, hold1, done1, err1, wl1}, {4'h0, 11'h0, 32'h0, 1'b1, 1'b0, 1'b0, 12'h0});
        end
    endtask

    task automatic test_two_word(input logic [7:0] csumDelta);
        doReset();
        tx = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h0C};
        tx.push_back(xorOf() ^ csumDelta);
        sendStream(0, 0);
        buildModel();
        checks++;
        if (got0 !== exp0 && !(got0.size() == exp0.size() && got0 == exp0)) begin
            errors++;
            $display("[TB] FAIL two_word_writes: got %0d writes (first %h) expected %0d (first %h)",
                     got0.size(), (got0.size() > 0) ? got0[0] : '0, exp0.size(), exp0[0]);
        end
        checks++;
        if ({done0, err0, hold0, wl0} !== {expDone, expErr, ~expDone, 12'(expWords)}) begin
            errors++;
            $display("[TB] FAIL two_word_status: got %h expected %h",
                     {done0, err0, hold0, wl0}, {expDone, expErr, ~expDone, 12'(expWords)});
        end
        // Bytes after the verdict must not move anything.
        tx.delete();
        tx = '{8'h00, 8'h01, 8'hAA, 8'h55, 8'h12};
        sendStream(0, 1);
        checks++;
        if ({got0.size() == 2, wl0, done0, err0} !== {1'b1, 12'd2, expDone, expErr}) begin
            errors++;
            $display("[TB] FAIL two_word_sticky: got %h expected %h",
                     {got0.size() == 2, wl0, done0, err0}, {1'b1, 12'd2, expDone, expErr});
        end
    endtask

    task automatic test_oversize();
        doReset();
        tx = '{8'h08, 8'h01};
        sendStream(0, 0);
        checks++;
        if ({err0, done0, hold0} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL oversize_err: got %b expected %b", {err0, done0, hold0}, 3'b101);
        end
        tx.delete();
        for (int i = 0; i < 12; i++) tx.push_back(8'($urandom));
        sendStream(0, 0);
        checks++;
        if (got0.size() != 0 || got1.size() != 0 || err0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oversize_nowrite: got %0d writes err=%b expected 0 writes err=1", got0.size(), err0);
        end
    endtask

    task automatic test_zero_len();
        for (int v = 0; v < 2; v++) begin
            doReset();
            tx = '{8'h00, 8'h00};
            tx.push_back(8'(v));
            sendStream(0, 0);
            buildModel();
            checks++;
            if ({got0.size() == 0, done0, err0, hold0} !== {1'b1, expDone, expErr, ~expDone}) begin
                errors++;
                $display("[TB] FAIL zero_len_%0d: got %b expected %b", v,
                         {got0.size() == 0, done0, err0, hold0}, {1'b1, expDone, expErr, ~expDone});
            end
        end
    endtask

    task automatic test_sparse_base();
        logic [31:0] word;
        doReset();
        word = $urandom;
        tx = '{8'h00, 8'h01, word[31:24], word[23:16], word[15:8], word[7:0]};
        tx.push_back(xorOf());
        sendStream(5, 5);
        buildModel();
        checks++;
        if (got1.size() != 1 || got1[0] !== exp1[0]) begin
            errors++;
            $display("[TB] FAIL sparse_write: got %0d writes (first %h) expected 1 (%h)",
                     got1.size(), (got1.size() > 0) ? got1[0] : '0, exp1[0]);
        end
        checks++;
        if ({addr1, din1, addr0, din0} !== {11'd1120, word, 11'd0, word}) begin
            errors++;
            $display("[TB] FAIL sparse_hold: got %h expected %h",
                     {addr1, din1, addr0, din0}, {11'd1120, word, 11'd0, word});
        end
        checks++;
        if ({done1, hold1, wl1} !== {1'b1, 1'b0, 12'd1}) begin
            errors++;
            $display("[TB] FAIL sparse_status: got %h expected %h", {done1, hold1, wl1}, {1'b1, 1'b0, 12'd1});
        end
    endtask

    task automatic test_wrap();
        doReset();
        tx = '{8'h03, 8'hA2};
        for (int i = 0; i < 4 * 930; i++) tx.push_back(8'($urandom));
        tx.push_back(xorOf());
        sendStream(0, 0);
        buildModel();
        checks++;
        if (got1 != exp1) begin
            errors++;
            $display("[TB] FAIL wrap_writes: got %0d writes (last %h) expected %0d (last %h)",
                     got1.size(), (got1.size() > 0) ? got1[got1.size()-1] : '0, exp1.size(), exp1[exp1.size()-1]);
        end
        checks++;
        if ({done1, err1, wl1} !== {1'b1, 1'b0, 12'd930}) begin
            errors++;
            $display("[TB] FAIL wrap_status: got %h expected %h", {done1, err1, wl1}, {1'b1, 1'b0, 12'd930});
        end
    endtask

    task automatic test_reset_mid_word();
        for (int v = 0; v < 2; v++) begin
            doReset();
            tx = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
            if (v == 1) tx.push_back(8'h77);
            sendStream(0, 0);
            // Reset lands together with a valid byte (the 4th byte when v == 1).
            reset    = 1'b1;
            rx_valid = 1'b1;
            rx_data  = 8'h88;
            @(posedge clk); #1;
            reset    = 1'b0;
            rx_valid = 1'b0;
            checks++;
            if ({we0, addr0, din0, hold0, done0, err0, wl0} !== {4'h0, 11'h0, 32'h0, 1'b1, 1'b0, 1'b0, 12'h0}) begin
                errors++;
                $display("[TB] FAIL mid_reset_values_%0d: got %h expected %h", v,
                         {we0, addr0, din0, hold0, done0, err0, wl0}, {4'h0, 11'h0, 32'h0, 1'b1, 1'b0, 1'b0, 12'h0});
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (got0.size() != 1) begin
                errors++;
                $display("[TB] FAIL mid_reset_writes_%0d: got %0d writes expected 1", v, got0.size());
            end
        end
        got0.delete();
        tx.delete();
        tx.push_back(8'h00);
        tx.push_back(8'h02);
        for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
        tx.push_back(xorOf());
        sendStream(0, 0);
        buildModel();
        checks++;
        if (got0 != exp0 || done0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_reload: got %0d writes done=%b expected %0d writes done=1",
                     got0.size(), done0, exp0.size());
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 20; it++) begin
            doReset();
            n = $urandom_range(6, 1);
            tx.push_back(8'h00);
            tx.push_back(8'(n));
            for (int i = 0; i < 4 * n; i++) tx.push_back(8'($urandom));
            if ($urandom_range(3, 0) == 0) tx.push_back(xorOf() ^ 8'(1 << $urandom_range(7, 0)));
            else tx.push_back(xorOf());
            sendStream(0, 2);
            buildModel();
            checks++;
            if (got0 != exp0 || got1 != exp1) begin
                errors++;
                $display("[TB] FAIL random_writes_%0d: got %0d/%0d writes expected %0d", it,
                         got0.size(), got1.size(), exp0.size());
            end
            checks++;
            if ({done0, err0, hold0, wl0, done1, err1} !== {expDone, expErr, ~expDone, 12'(expWords), expDone, expErr}) begin
                errors++;
                $display("[TB] FAIL random_status_%0d: got %h expected %h", it,
                         {done0, err0, hold0, wl0, done1, err1}, {expDone, expErr, ~expDone, 12'(expWords), expDone, expErr});
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_two_word(8'h00);
        test_two_word(8'h01);
        test_oversize();
        test_zero_len();
        test_sparse_base();
        test_wrap();
        test_reset_mid_word();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
